// File: rtl/disp_capture_pkg.sv
// Shared constants for the seven-segment loopback monitor: active-low glyphs,
// anode select codes and the sample record type.
package disp_capture_pkg;

  // Segment order is {a,b,c,d,e,f,g}; a 0 bit means the segment is lit.
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_NONE = 4'hF;
  localparam logic [3:0] AN_0    = 4'hE;
  localparam logic [3:0] AN_1    = 4'hD;
  localparam logic [3:0] AN_2    = 4'hB;
  localparam logic [3:0] AN_3    = 4'h7;
  localparam logic [3:0][3:0] AN_SLOT = {AN_3, AN_2, AN_1, AN_0};

  localparam logic [3:0] BCD_BAD = 4'hF;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } smp_t;

  localparam smp_t SMP_IDLE = '{an: AN_NONE, seg: SEG_BLANK};

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the seven-segment glyph table; valid drops for any
// pattern that is not one of the ten digit glyphs.
module seg7_to_bcd
  import disp_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = BCD_BAD;
    valid = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/disp_capture.sv
// Loopback monitor for the multiplexed display: deglitches the scanned lines,
// decodes each accepted slot and publishes complete four-digit frames.
module disp_capture
  import disp_capture_pkg::*;
#(
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] an,
  input  logic [6:0] a_to_g,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       stalled
);

  localparam int STAB_W = $clog2(SETTLE + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE);
  localparam logic [STAB_W-1:0] STAB_ARM = STAB_W'(SETTLE - 2);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);

  smp_t              smp_reg, smp_d_reg;
  logic [STAB_W-1:0] stab_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [3:0]        pend_reg [4];
  logic [3:0]        digit_reg [4];
  logic [3:0]        mask_reg, mask_next;
  logic              frame_valid_reg, seg_err_reg;

  logic [3:0] slot_hit;
  logic       same, accept;
  logic [3:0] dec_bcd, dec_val;
  logic       dec_valid;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot_hit[gi] = (smp_reg.an == AN_SLOT[gi]);
  end

  // Blanked or multi-digit anode patterns never match a single slot code.
  assign same   = (smp_reg == smp_d_reg);
  assign accept = same && (stab_reg == STAB_ARM) && (|slot_hit);

  seg7_to_bcd u_dec (
    .seg   (smp_reg.seg),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  assign dec_val = dec_valid ? dec_bcd : BCD_BAD;

  always_comb begin
    mask_next = mask_reg;
    if (mask_reg == 4'hF) mask_next = 4'h0;
    if (accept) mask_next = mask_next | slot_hit;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      smp_reg         <= SMP_IDLE;
      smp_d_reg       <= SMP_IDLE;
      stab_reg        <= '0;
      wd_reg          <= '0;
      mask_reg        <= '0;
      frame_valid_reg <= 1'b0;
      seg_err_reg     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pend_reg[i]  <= '0;
        digit_reg[i] <= '0;
      end
    end else begin
      smp_reg   <= '{an: an, seg: a_to_g};
      smp_d_reg <= smp_reg;

      if (!same)                 stab_reg <= '0;
      else if (stab_reg != STAB_MAX) stab_reg <= stab_reg + 1'b1;

      if (accept)              wd_reg <= '0;
      else if (wd_reg != WD_MAX) wd_reg <= wd_reg + 1'b1;

      mask_reg        <= mask_next;
      frame_valid_reg <= (mask_reg == 4'hF);
      if (accept && !dec_valid) seg_err_reg <= 1'b1;

      for (int i = 0; i < 4; i++) begin
        if (accept && slot_hit[i]) pend_reg[i] <= dec_val;
        if (mask_reg == 4'hF)      digit_reg[i] <= pend_reg[i];
      end
    end
  end

  assign digit0      = digit_reg[0];
  assign digit1      = digit_reg[1];
  assign digit2      = digit_reg[2];
  assign digit3      = digit_reg[3];
  assign frame_valid = frame_valid_reg;
  assign seg_err     = seg_err_reg;
  assign stalled     = (wd_reg == WD_MAX);

endmodule
